stream_inst_issue5: RTL and testbench

- Synchronous issue stage directly upstream of the 5-way conditional split.
- Buffers incoming instruction words and decodes each opcode into a one-hot lane select (valid0..valid4).
- Presents the select and payload, fires one drive pulse into the split, then holds everything stable until the split returns free.
- Bridges the clocked instruction stream into the self-timed drive/free handshake.

---
 rtl/stream_issue_pkg.sv | 43 ++++
 rtl/stream_inst_fifo.sv | 54 +++++
 rtl/stream_inst_issue5.sv | 135 +++++++++++++
 tb/tb_stream_inst_issue5.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_issue_pkg.sv
// Shared types for the 5-lane instruction issue stage: lane opcodes, FSM states, lane decode.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stream_issue_pkg;

    localparam int LANES = 5;
    localparam int OPC_W = 3;

    localparam logic [OPC_W-1:0] OP_L0 = 3'd0;
    localparam logic [OPC_W-1:0] OP_L1 = 3'd1;
    localparam logic [OPC_W-1:0] OP_L2 = 3'd2;
    localparam logic [OPC_W-1:0] OP_L3 = 3'd3;
    localparam logic [OPC_W-1:0] OP_L4 = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        DRIVE,
        WAIT_FREE
    } issueState_t;

    typedef struct packed {
        logic             legal;
        logic [LANES-1:0] sel;
    } laneDec_t;

    // Opcodes above OP_L4 have no lane and come back with legal=0, sel=0.
    function automatic laneDec_t decodeLane(input logic [OPC_W-1:0] opc);
        laneDec_t d;
        d.legal = 1'b1;
        d.sel   = '0;
        case (opc)
            OP_L0:   d.sel = 5'b00001;
            OP_L1:   d.sel = 5'b00010;
            OP_L2:   d.sel = 5'b00100;
            OP_L3:   d.sel = 5'b01000;
            OP_L4:   d.sel = 5'b10000;
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/stream_inst_fifo.sv
// Synchronous instruction FIFO with registered read data.
// Latency: popped word appears on popDat the clock after popReq.
// Backpressure: pushes ignored while full, pops ignored while empty.
module stream_inst_fifo #(
    parameter int DEPTH  = 4,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pushVld,
    input  logic [INST_W-1:0] pushDat,
    input  logic              popReq,
    output logic [INST_W-1:0] popDat,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wrPtr;
    logic [AW:0]       rdPtr;
    logic [INST_W-1:0] mem [DEPTH];
    logic              doPush;
    logic              doPop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty  = (wrPtr == rdPtr);
    assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign doPush = pushVld && !full;
    assign doPop  = popReq && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            popDat <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + (AW+1)'(1);
            end
            if (doPop) begin
                rdPtr  <= rdPtr + (AW+1)'(1);
                popDat <= mem[rdPtr[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr[AW-1:0]] <= pushDat;
        end
    end

endmodule

// File: rtl/stream_inst_issue5.sv
// Issue stage: buffers instructions, decodes a one-hot lane, fires one drive pulse and waits for free.
// Latency: push at edge N -> o_valid after N+2 -> o_drive after N+2+SETUP_CYC.
// Backpressure: in_ready drops while the FIFO is full; the stage holds until free returns.
module stream_inst_issue5
    import stream_issue_pkg::*;
#(
    parameter int INST_W    = 32,
    parameter int DEPTH     = 4,
    parameter int SETUP_CYC = 2,
    parameter int TIMEOUT   = 1024,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    output logic              o_drive,
    output logic [LANES-1:0]  o_valid,
    output logic [INST_W-1:0] o_data,
    input  logic              i_free,
    output logic              busy,
    output logic [CNT_W-1:0]  issue_cnt,
    output logic              err_illegal,
    output logic              err_spurious,
    output logic              err_timeout
);

    localparam int SCNT_W = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
    localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    issueState_t       state;
    logic              popPending;
    logic [SCNT_W-1:0] setupCnt;
    logic [TCNT_W-1:0] toCnt;
    logic              fifoFull;
    logic              fifoEmpty;
    logic              fifoPop;
    logic [INST_W-1:0] headInst;
    laneDec_t          headDec;
    logic [1:0]        freeSync;
    logic              freeDly;
    logic              freeEvt;

    stream_inst_fifo #(
        .DEPTH  (DEPTH),
        .INST_W (INST_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .pushVld (in_valid),
        .pushDat (in_inst),
        .popReq  (fifoPop),
        .popDat  (headInst),
        .full    (fifoFull),
        .empty   (fifoEmpty)
    );

    assign in_ready = !fifoFull;
    assign fifoPop  = (state == IDLE) && !popPending && !fifoEmpty;
    assign headDec  = decodeLane(headInst[INST_W-1 -: OPC_W]);
    assign freeEvt  = freeSync[1] && !freeDly;
    assign busy     = (state != IDLE) || popPending || !fifoEmpty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            popPending   <= 1'b0;
            setupCnt     <= '0;
            toCnt        <= '0;
            freeSync     <= '0;
            freeDly      <= 1'b0;
            o_drive      <= 1'b0;
            o_valid      <= '0;
            o_data       <= '0;
            issue_cnt    <= '0;
            err_illegal  <= 1'b0;
            err_spurious <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            freeSync <= {freeSync[0], i_free};
            freeDly  <= freeSync[1];
            o_drive  <= 1'b0;

            if (freeEvt && (state != WAIT_FREE)) begin
                err_spurious <= 1'b1;
            end

            case (state)
                IDLE: begin
                    // popPending marks that headInst holds the word popped last clock.
                    if (popPending) begin
                        popPending <= 1'b0;
                        if (headDec.legal) begin
                            o_valid  <= headDec.sel;
                            o_data   <= headInst;
                            setupCnt <= '0;
                            state    <= SETUP;
                        end else begin
                            err_illegal <= 1'b1;
                        end
                    end else if (fifoPop) begin
                        popPending <= 1'b1;
                    end
                end
                SETUP: begin
                    if (setupCnt == SCNT_W'(SETUP_CYC - 1)) begin
                        o_drive <= 1'b1;
                        state   <= DRIVE;
                    end else begin
                        setupCnt <= setupCnt + SCNT_W'(1);
                    end
                end
                DRIVE: begin
                    issue_cnt <= issue_cnt + CNT_W'(1);
                    toCnt     <= '0;
                    state     <= WAIT_FREE;
                end
                WAIT_FREE: begin
                    // Timeout only flags; the lane stays selected until free arrives.
                    if (freeEvt) begin
                        o_valid <= '0;
                        state   <= IDLE;
                    end else if (toCnt == TCNT_W'(TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                    end else begin
                        toCnt <= toCnt + TCNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_inst_issue5.sv
// Bench for stream_inst_issue5: timestamp-based reference model plus directed scenarios.
module tb_stream_inst_issue5;

    localparam int INST_W    = 32;
    localparam int DEPTH     = 4;
    localparam int SETUP_CYC = 2;
    localparam int TIMEOUT   = 16;
    localparam int CNT_W     = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [INST_W-1:0] in_inst;
    logic              o_drive;
    logic [4:0]        o_valid;
    logic [INST_W-1:0] o_data;
    logic              i_free;
    logic              busy;
    logic [CNT_W-1:0]  issue_cnt;
    logic              err_illegal;
    logic              err_spurious;
    logic              err_timeout;

    int nCmp = 0;
    int nBad = 0;
    bit cmpEn = 1'b0;

    stream_inst_issue5 #(
        .INST_W    (INST_W),
        .DEPTH     (DEPTH),
        .SETUP_CYC (SETUP_CYC),
        .TIMEOUT   (TIMEOUT),
        .CNT_W     (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_inst      (in_inst),
        .o_drive      (o_drive),
        .o_valid      (o_valid),
        .o_data       (o_data),
        .i_free       (i_free),
        .busy         (busy),
        .issue_cnt    (issue_cnt),
        .err_illegal  (err_illegal),
        .err_spurious (err_spurious),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: instructions as a queue, stage progress as edge timestamps.
    int                cyc;
    logic [INST_W-1:0] fq[$];
    logic [INST_W-1:0] heldW;
    bit                held;
    int                tPop, tLoad, tDrv, tWait;
    bit                waiting;
    int                waitEdges;
    bit   [3:0]        fs;
    logic [4:0]        mLanes;
    logic [INST_W-1:0] mData;
    bit                mDrive;
    int                mIssues;
    bit                eIll, eSp, eTo;

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                cyc = 0; fq.delete(); held = 0; heldW = '0;
                tPop = -1; tLoad = -1; tDrv = -1; tWait = -1;
                waiting = 0; waitEdges = 0; fs = '0;
                mLanes = '0; mData = '0; mDrive = 0; mIssues = 0;
                eIll = 0; eSp = 0; eTo = 0;
            end else begin
                bit freeAct;
                bit accept;
                cyc++;
                fs      = {fs[2:0], i_free};
                freeAct = fs[2] && !fs[3];
                if (freeAct && !waiting) eSp = 1;
                accept = in_valid && (fq.size() < DEPTH);
                if (cyc == tPop) begin
                    heldW = fq.pop_front();
                    held  = 1;
                    tPop  = -1;
                    tLoad = cyc + 1;
                end
                if (accept) fq.push_back(in_inst);
                if (cyc == tLoad) begin
                    tLoad = -1;
                    if (heldW[INST_W-1 -: 3] <= 3'd4) begin
                        mLanes = 5'd1 << heldW[INST_W-1 -: 3];
                        mData  = heldW;
                        tDrv   = cyc + SETUP_CYC;
                        tWait  = tDrv + 1;
                    end else begin
                        eIll = 1;
                        held = 0;
                    end
                end
                if (cyc == tDrv) mDrive = 1;
                if (cyc == tWait) begin
                    mDrive = 0;
                    mIssues++;
                    waiting = 1;
                    waitEdges = 0;
                end else if (waiting && freeAct) begin
                    mLanes  = '0;
                    waiting = 0;
                    held    = 0;
                end else if (waiting) begin
                    waitEdges++;
                    if (waitEdges >= TIMEOUT) eTo = 1;
                end
                if (!held && tPop < 0 && fq.size() > 0) tPop = cyc + 1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst && cmpEn) begin
                chk("in_ready", in_ready, fq.size() < DEPTH);
                chk("busy", busy, held || (fq.size() > 0));
                chk("o_valid", o_valid, mLanes);
                chk("onehot0", $onehot0(o_valid), 1);
                if (mLanes != 0) chk("o_data", o_data, mData);
                chk("o_drive", o_drive, mDrive);
                chk("issue_cnt", issue_cnt, 16'(mIssues));
                chk("err_illegal", err_illegal, eIll);
                chk("err_spurious", err_spurious, eSp);
                chk("err_timeout", err_timeout, eTo);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic doReset();
        rst = 1'b0;
        in_valid = 1'b0;
        i_free = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic waitDrive(input string name);
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            if (o_drive) begin
                ok = 1;
                break;
            end
            step();
        end
        chk(name, ok, 1);
    endtask

    task automatic waitIdle(input string name);
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) begin
                ok = 1;
                break;
            end
            step();
        end
        chk(name, ok, 1);
    endtask

    task automatic pulseFree();
        i_free = 1'b1;
        step();
        step();
        i_free = 1'b0;
    endtask

    logic [INST_W-1:0] words[5];
    logic [4:0]        lanes[5];

    initial begin
        words = '{32'h0000_1000, 32'h2000_1001, 32'h4000_1002, 32'h6000_1003, 32'h8000_1004};
        lanes = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};
        rst = 1'b1; in_valid = 1'b0; in_inst = '0; i_free = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_drive", o_drive, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_issue_cnt", issue_cnt, 0);
        chk("rst_errs", {err_illegal, err_spurious, err_timeout}, 0);
        step();
        rst = 1'b1;
        cmpEn = 1'b1;
        step();

        // Single instruction: lane 2, drive two clocks after the lane appears.
        in_valid = 1'b1; in_inst = 32'h4000_A5A5;
        step();
        in_valid = 1'b0;
        chk("t1_valid_e0", o_valid, 0);
        step();
        chk("t1_valid_e1", o_valid, 0);
        step();
        chk("t1_valid_e2", o_valid, 5'b00100);
        chk("t1_data_e2", o_data, 32'h4000_A5A5);
        step();
        chk("t1_drive_e3", o_drive, 0);
        step();
        chk("t1_drive_e4", o_drive, 1);
        step();
        chk("t1_drive_e5", o_drive, 0);
        chk("t1_cnt_e5", issue_cnt, 1);
        repeat (3) step();
        pulseFree();
        waitIdle("t1_idle");
        chk("t1_valid_end", o_valid, 0);
        chk("t1_cnt_end", issue_cnt, 1);

        // Back-to-back pushes, lanes must come out in push order.
        doReset();
        begin
            int idx = 0;
            in_valid = 1'b1;
            for (int g = 0; g < 40 && idx < 5; g++) begin
                bit acc;
                in_inst = words[idx];
                acc = in_ready;
                step();
                if (acc) idx++;
            end
            in_valid = 1'b0;
            chk("t2_all_pushed", idx, 5);
        end
        for (int k = 0; k < 5; k++) begin
            waitDrive("t2_drive");
            chk("t2_lane", o_valid, lanes[k]);
            chk("t2_data", o_data, words[k]);
            repeat (3) step();
            pulseFree();
        end
        waitIdle("t2_idle");
        chk("t2_cnt", issue_cnt, 5);

        // Illegal opcode is dropped, the following legal one issues.
        doReset();
        in_valid = 1'b1; in_inst = 32'hC000_0001;
        step();
        in_inst = 32'h2000_0002;
        step();
        in_valid = 1'b0;
        waitDrive("t3_drive");
        chk("t3_illegal", err_illegal, 1);
        chk("t3_lane", o_valid, 5'b00010);
        chk("t3_data", o_data, 32'h2000_0002);
        pulseFree();
        waitIdle("t3_idle");
        chk("t3_cnt", issue_cnt, 1);

        // Free while idle is flagged and otherwise ignored.
        doReset();
        i_free = 1'b1;
        repeat (3) step();
        i_free = 1'b0;
        repeat (3) step();
        chk("t4_spurious", err_spurious, 1);
        chk("t4_valid", o_valid, 0);
        chk("t4_busy", busy, 0);
        chk("t4_cnt", issue_cnt, 0);

        // Timeout flags after TIMEOUT clocks in WAIT_FREE, lane held.
        doReset();
        in_valid = 1'b1; in_inst = 32'h6000_0003;
        step();
        in_valid = 1'b0;
        waitDrive("t5_drive");
        step();
        repeat (15) step();
        chk("t5_to_early", err_timeout, 0);
        step();
        chk("t5_to_set", err_timeout, 1);
        chk("t5_lane", o_valid, 5'b01000);
        pulseFree();
        waitIdle("t5_idle");
        chk("t5_valid_end", o_valid, 0);
        chk("t5_spurious", err_spurious, 0);

        // Reset during WAIT_FREE with two entries queued.
        doReset();
        in_valid = 1'b1; in_inst = 32'h8000_0004;
        step();
        in_valid = 1'b0;
        waitDrive("t6_drive");
        step();
        in_valid = 1'b1; in_inst = 32'h0000_0010;
        step();
        in_inst = 32'h2000_0020;
        step();
        in_valid = 1'b0;
        chk("t6_pre_lane", o_valid, 5'b10000);
        #1 rst = 1'b0;
        #1;
        chk("t6_rst_valid", o_valid, 0);
        chk("t6_rst_drive", o_drive, 0);
        chk("t6_rst_ready", in_ready, 1);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_cnt", issue_cnt, 0);
        chk("t6_rst_data", o_data, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (20) step();
        chk("t6_busy", busy, 0);
        chk("t6_cnt", issue_cnt, 0);
        chk("t6_valid", o_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
